// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: level request held until a one-cycle ack.
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_ren,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_ren,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts request cycles without ack; expired flags the cycle whose increment reaches TIMEOUT.
// Saturates at 8'hFF so a stuck enable can never wrap back to zero.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (enable && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired = enable && (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/instr_fetch.sv
// Multicycle fetch: samples pc in IDLE, reads one word, delivers it with a one-cycle iready pulse.
// Min period 3 cycles (+1 per memory wait, +stall cycles); misalign/timeout lock into FAULT until reset.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              stall,
  instr_fetch_if.master     mem,
  output logic [DATA_W-1:0] instr,
  output logic              iready,
  output logic              fetch_fault
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              ctr_clear;
  logic              ctr_enable;
  logic              ctr_expired;

  assign ctr_clear  = (state_q == IDLE);
  assign ctr_enable = (state_q == REQ) && !mem.mem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .nRST    (nRST),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // In REQ: flush beats ack, and ack beats an expiring counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pc[1:0] != 2'b00) ? FAULT : REQ;
      REQ: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem.mem_ack) begin
          state_d = stall ? HOLD : DONE;
        end else if (ctr_expired) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!stall) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      addr_q  <= '0;
      instr_q <= DATA_W'(NOP_INSTR);
    end else begin
      if (state_q == IDLE) begin
        addr_q <= pc;
      end
      if (state_d == FAULT) begin
        instr_q <= DATA_W'(NOP_INSTR);
      end else if ((state_q == REQ) && mem.mem_ack && !flush) begin
        instr_q <= mem.mem_rdata;
      end
    end
  end

  assign mem.mem_ren  = (state_q == REQ);
  assign mem.mem_addr = addr_q;
  assign iready       = (state_q == DONE);
  assign fetch_fault  = (state_q == FAULT);
  assign instr        = instr_q;
endmodule
